// File: rtl/buf_fifo.sv
// buf_fifo: WIDTH-bit, DEPTH-entry elastic buffer with valid/ready on both sides.
// Define BUF_FIFO_BYPASS_EN for fall-through from i to q when the buffer is empty.
module buf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       ck,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           i,
    input  logic                       i_v,
    output logic                       i_r,
    output logic [WIDTH-1:0]           q,
    output logic                       q_v,
    input  logic                       q_r,
    output logic [$clog2(DEPTH+1)-1:0] cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stored_v;
    logic             push;
    logic             pop;
`ifdef BUF_FIFO_BYPASS_EN
    logic             bypass;
`endif

    // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stored_v = (cnt_q != '0) && !rst;
        i_r      = (cnt_q != FULL_CNT) && !rst;
        cnt      = rst ? '0 : cnt_q;
        pop      = stored_v && q_r;
`ifdef BUF_FIFO_BYPASS_EN
        bypass   = (cnt_q == '0) && i_v && !rst;
        q_v      = stored_v || bypass;
        q        = stored_v ? mem[rd_ptr_q] : (bypass ? i : '0);
        // A word taken straight through by the consumer is never stored.
        push     = i_v && i_r && !(bypass && q_r);
`else
        q_v      = stored_v;
        q        = stored_v ? mem[rd_ptr_q] : '0;
        push     = i_v && i_r;
`endif

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ck) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: storage is deliberately not reset; cnt and the pointers alone decide what is valid.
    always_ff @(posedge ck) begin
        if (push) begin
            mem[wr_ptr_q] <= i;
        end
    end

endmodule

// File: tb/tb_buf_fifo.sv
// Directed self-checking bench for buf_fifo (DEPTH=4 main instance, DEPTH=3 wrap instance).
module tb_buf_fifo;

`ifdef BUF_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       ck;
    int         checks;
    int         failures;

    // DEPTH=4 instance
    logic       rst;
    logic [7:0] i;
    logic       i_v;
    logic       i_r;
    logic [7:0] q;
    logic       q_v;
    logic       q_r;
    logic [2:0] cnt;

    // DEPTH=3 instance
    logic       rst3;
    logic [7:0] i3;
    logic       i_v3;
    logic       i_r3;
    logic [7:0] q3;
    logic       q_v3;
    logic       q_r3;
    logic [1:0] cnt3;

    buf_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .ck(ck), .rst(rst), .i(i), .i_v(i_v), .i_r(i_r),
        .q(q), .q_v(q_v), .q_r(q_r), .cnt(cnt)
    );

    buf_fifo #(.WIDTH(8), .DEPTH(3)) dut3 (
        .ck(ck), .rst(rst3), .i(i3), .i_v(i_v3), .i_r(i_r3),
        .q(q3), .q_v(q_v3), .q_r(q_r3), .cnt(cnt3)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and return to the following falling edge.
    task automatic step();
        @(posedge ck);
        @(negedge ck);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst  = 1'b1; i  = 8'hAA; i_v  = 1'b1; q_r  = 1'b0;
        rst3 = 1'b1; i3 = 8'h00; i_v3 = 1'b0; q_r3 = 1'b0;
        @(negedge ck);
        step();
        step();
        #1;
        chk("rst_i_r", i_r, 0);
        chk("rst_q_v", q_v, 0);
        chk("rst_q", q, 8'h00);
        chk("rst_cnt", cnt, 0);

        // Release reset; nothing should have been stored.
        @(negedge ck);
        rst = 1'b0; rst3 = 1'b0; i_v = 1'b0;
        #1;
        chk("rel_i_r", i_r, 1);
        chk("rel_q_v", q_v, 0);
        chk("rel_cnt", cnt, 0);
        chk("rel3_cnt", cnt3, 0);

        // Fill to full with the consumer stalled.
        @(negedge ck);
        for (int k = 0; k < 4; k++) begin
            i_v = 1'b1; i = 8'(8'h11 * (k + 1)); q_r = 1'b0;
            step();
        end
        #1;
        chk("full_cnt", cnt, 4);
        chk("full_i_r", i_r, 0);
        chk("full_q", q, 8'h11);
        i = 8'h55; i_v = 1'b1;
        step();
        #1;
        chk("drop_cnt", cnt, 4);
        i_v = 1'b0; q_r = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_q_v", q_v, 1);
            chk("drain_q", q, 8'(8'h11 * (k + 1)));
            step();
        end
        #1;
        chk("drain_empty_q_v", q_v, 0);
        chk("drain_empty_cnt", cnt, 0);
        chk("drain_empty_q", q, 8'h00);

        // Simultaneous push and pop while full: only the pop happens.
        q_r = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_v = 1'b1; i = 8'(8'hA0 + k);
            step();
        end
        i_v = 1'b1; i = 8'hB0; q_r = 1'b1;
        #1;
        chk("pp_full_i_r", i_r, 0);
        chk("pp_full_q", q, 8'hA0);
        step();
        i_v = 1'b0; q_r = 1'b0;
        #1;
        chk("pp_full_cnt", cnt, 3);
        chk("pp_full_i_r_next", i_r, 1);
        chk("pp_full_q_next", q, 8'hA1);
        q_r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("pp_drain_q", q, 8'(8'hA1 + k));
            step();
        end
        #1;
        chk("pp_drain_cnt", cnt, 0);

        // Streaming 0..15 with both sides always ready.
        i_v = 1'b1; q_r = 1'b1;
        for (int n = 0; n < 16; n++) begin
            i = 8'(n);
            #1;
            if (n > 0 || BYP) begin
                chk("stream_q_v", q_v, 1);
                chk("stream_q", q, BYP ? 32'(n) : 32'(n - 1));
                chk("stream_cnt", cnt, BYP ? 0 : 1);
            end else begin
                chk("stream_first_q_v", q_v, 0);
            end
            step();
        end
        i_v = 1'b0;
        #1;
        chk("stream_tail_q_v", q_v, BYP ? 0 : 1);
        chk("stream_tail_q", q, BYP ? 8'h00 : 8'h0F);
        step();
        #1;
        chk("stream_end_cnt", cnt, 0);

        // Fall-through behaviour on an empty buffer.
        q_r = 1'b1; i_v = 1'b1; i = 8'h5A;
        #1;
        chk("byp_q_v", q_v, BYP ? 1 : 0);
        chk("byp_q", q, BYP ? 8'h5A : 8'h00);
        step();
        i_v = 1'b0; q_r = 1'b0;
        #1;
        chk("byp_cnt", cnt, BYP ? 0 : 1);
        q_r = 1'b1;
        step();
        #1;
        chk("byp_cleared_cnt", cnt, 0);
        q_r = 1'b0; i_v = 1'b1; i = 8'hA5;
        #1;
        chk("byp_stall_q_v", q_v, BYP ? 1 : 0);
        step();
        i_v = 1'b0;
        #1;
        chk("byp_stall_cnt", cnt, 1);
        chk("byp_stall_q", q, 8'hA5);

        // DEPTH=3: wrap both pointers twice, then reset mid-operation.
        i_v3 = 1'b1; i3 = 8'h30; q_r3 = 1'b0;
        step();
        for (int n = 1; n <= 7; n++) begin
            i_v3 = 1'b1; i3 = 8'(8'h30 + n); q_r3 = 1'b1;
            #1;
            chk("wrap_q", q3, 8'(8'h30 + n - 1));
            chk("wrap_cnt", cnt3, 1);
            step();
        end
        i_v3 = 1'b1; i3 = 8'h38; q_r3 = 1'b0;
        step();
        i_v3 = 1'b0;
        #1;
        chk("wrap_pre_rst_cnt", cnt3, 2);
        chk("wrap_pre_rst_q", q3, 8'h37);
        rst3 = 1'b1; i_v3 = 1'b1; i3 = 8'hEE; q_r3 = 1'b1;
        #1;
        chk("mid_rst_cnt", cnt3, 0);
        chk("mid_rst_q_v", q_v3, 0);
        chk("mid_rst_i_r", i_r3, 0);
        step();
        rst3 = 1'b0; i_v3 = 1'b0; q_r3 = 1'b0;
        #1;
        chk("post_rst_cnt", cnt3, 0);
        chk("post_rst_q_v", q_v3, 0);
        chk("post_rst_q", q3, 8'h00);
        step();
        #1;
        chk("post_rst_cnt_hold", cnt3, 0);
        chk("post_rst_q_v_hold", q_v3, 0);
        i_v3 = 1'b1; i3 = 8'h99;
        step();
        i_v3 = 1'b0;
        #1;
        chk("post_rst_new_q", q3, 8'h99);
        chk("post_rst_new_cnt", cnt3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
